// File: rtl/lsu_dmem_ctrl.sv
// Load/store initiator between the memory stage and a word-organised data memory.
// Latency: accept N, memory access N+1, response N+2 (errors respond in N+1); one request in flight, ready only in IDLE.
module lsu_dmem_ctrl #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] BASE_ADDR  = '0,
  parameter int              SIZE_BYTES = 4096
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_resp_valid,
  output logic [XLEN-1:0] o_resp_rdata,
  output logic            o_resp_err,
  output logic            o_mem_we,
  output logic [3:0]      o_mem_amp,
  output logic [XLEN-1:0] o_mem_a,
  output logic [XLEN-1:0] o_mem_wd,
  input  logic [XLEN-1:0] i_mem_rd
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_t;

  localparam logic [XLEN:0] LP_END = {1'b0, BASE_ADDR} + (XLEN+1)'(SIZE_BYTES);

  state_t          r_state, w_state_nxt;
  logic            r_we, r_err;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [3:0]      r_amp;
  logic [XLEN-1:0] r_mem_a, r_mem_wd, r_rdata;

  logic            w_accept, w_f3_ok, w_align, w_in_range, w_legal;
  logic [3:0]      w_amp;
  logic [XLEN-1:0] w_wd, w_ld;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  assign o_req_ready = (r_state == S_IDLE) & ~i_reset;
  assign w_accept    = i_req_valid & o_req_ready;

  always_comb begin
    w_f3_ok = 1'b0;
    case (i_req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
      default:                                w_f3_ok = 1'b0;
    endcase
    case (i_req_funct3[1:0])
      2'b01:   w_align = ~i_req_addr[0];
      2'b10:   w_align = (i_req_addr[1:0] == 2'b00);
      default: w_align = 1'b1;
    endcase
  end

  // Only the first byte is range-checked; alignment keeps the rest inside the window.
  assign w_in_range = ({1'b0, i_req_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, i_req_addr} < LP_END);
  assign w_legal    = w_f3_ok & w_align & w_in_range & ~(i_req_we & i_req_funct3[2]);

  always_comb begin
    case (i_req_funct3[1:0])
      2'b00:   begin w_amp = 4'b0001 << i_req_addr[1:0];            w_wd = {4{i_req_wdata[7:0]}};  end
      2'b01:   begin w_amp = i_req_addr[1] ? 4'b1100 : 4'b0011;     w_wd = {2{i_req_wdata[15:0]}}; end
      default: begin w_amp = 4'b1111;                               w_wd = i_req_wdata;            end
    endcase
  end

  assign w_byte = i_mem_rd[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];

  always_comb begin
    case (r_funct3)
      3'b000:  w_ld = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_ld = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_ld = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_ld = {{(XLEN-16){1'b0}}, w_half};
      default: w_ld = i_mem_rd;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_legal ? S_ACC : S_RESP;
      S_ACC:   w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
      r_amp    <= 4'b0000;
      r_mem_a  <= '0;
      r_mem_wd <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we     <= i_req_we;
        r_funct3 <= i_req_funct3;
        r_off    <= i_req_addr[1:0];
        r_err    <= ~w_legal;
        r_rdata  <= '0;
        if (w_legal) begin
          r_amp    <= w_amp;
          r_mem_a  <= i_req_addr;
          r_mem_wd <= w_wd;
        end
      end
      if (r_state == S_ACC && !r_we) r_rdata <= w_ld;
    end
  end

  // Write enable is gated by reset combinationally so a reset in ACC blocks the store.
  assign o_mem_we     = (r_state == S_ACC) & r_we & ~i_reset;
  assign o_mem_amp    = (r_state == S_ACC) ? r_amp : 4'b0000;
  assign o_mem_a      = r_mem_a;
  assign o_mem_wd     = r_mem_wd;
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: byte-array reference model, directed plan cases, then randomized traffic.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;
  logic [3:0]  mem_amp;

  lsu_dmem_ctrl #(.XLEN(32), .BASE_ADDR(32'h0), .SIZE_BYTES(4096)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_mem_we(mem_we), .o_mem_amp(mem_amp), .o_mem_a(mem_a), .o_mem_wd(mem_wd),
    .i_mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = 0;
  int prev_gap = 3;

  logic [31:0] dmem    [0:1023];
  logic [7:0]  ref_mem [0:4095];

  assign mem_rd = dmem[mem_a[11:2]];

  always @(posedge clk) cyc++;

  // Memory side: apply writes mid-cycle while the enable is stable.
  always @(negedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_amp[i]) dmem[mem_a[11:2]][8*i +: 8] = mem_wd[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int n;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (we && f3[2]) return 1'b0;
    n = 1 << f3[1:0];
    if ((addr % n) != 0) return 1'b0;
    return addr < 32'd4096;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    logic [31:0] v, ones;
    n = 1 << f3[1:0];
    v = 0;
    ones = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[addr + k]) << (8 * k));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (ones << (8 * n));
    return v;
  endfunction

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input bit garbage, input bit chk_gap);
    bit ok, got;
    int n, nwr, w;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_amp;
    ok = ref_legal(we, f3, addr);
    n = 1 << f3[1:0];
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 10) begin @(negedge clk); w++; end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (chk_gap) check("accept_gap", 32'(cyc - last_acc), 32'(prev_gap));
    last_acc = cyc;
    if (garbage) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = {20'd0, 10'($urandom_range(0, 1023)), 2'b00}; req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    exp_rd = 0; exp_wd = 0;
    exp_amp = 4'(((1 << n) - 1) << addr[1:0]);
    if (ok && we) begin
      for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
      for (int k = 0; k < n; k++) ref_mem[addr + k] = wd[8*k +: 8];
    end else if (ok) begin
      exp_rd = ref_load(f3, addr);
    end
    got = 0; nwr = 0;
    for (int c = 1; c <= 3 && !got; c++) begin
      @(negedge clk);
      check("busy_ready", 32'(req_ready), 32'd0);
      if (ok && c == 1) begin
        check("mem_a", mem_a, addr);
        check("mem_amp", 32'(mem_amp), 32'(exp_amp));
        if (we) check("mem_wd", mem_wd, exp_wd);
      end else begin
        check("amp_idle", 32'(mem_amp), 32'd0);
      end
      if (mem_we) nwr++;
      if (resp_valid) begin
        got = 1;
        check("resp_lat", 32'(c), ok ? 32'd2 : 32'd1);
        check("resp_err", 32'(resp_err), 32'(!ok));
        check("resp_rdata", resp_rdata, exp_rd);
      end
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
    check("we_count", 32'(nwr), (ok && we) ? 32'd1 : 32'd0);
    req_valid = 1'b0;
    prev_gap = ok ? 3 : 2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    logic        we;
    int          idle, n;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = dmem[i][8*b +: 8];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_amp", 32'(mem_amp), 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    check("rst_ready_low", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1);
    txn(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b1, 1'b1);
    txn(1'b1, 3'b001, 32'h12, 32'h00001234, 1'b1, 1'b1);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1);
    txn(1'b1, 3'b010, 32'h40, 32'h80FF7F01, 1'b0, 1'b1);
    txn(1'b0, 3'b000, 32'h41, 32'h0, 1'b0, 1'b1);
    txn(1'b0, 3'b000, 32'h42, 32'h0, 1'b0, 1'b1);
    txn(1'b0, 3'b100, 32'h43, 32'h0, 1'b0, 1'b1);
    txn(1'b0, 3'b001, 32'h42, 32'h0, 1'b0, 1'b1);
    txn(1'b0, 3'b101, 32'h40, 32'h0, 1'b0, 1'b1);
    txn(1'b0, 3'b010, 32'h2, 32'h0, 1'b1, 1'b1);
    txn(1'b1, 3'b001, 32'h5, 32'h1111, 1'b0, 1'b1);
    txn(1'b0, 3'b011, 32'h20, 32'h0, 1'b0, 1'b1);
    txn(1'b1, 3'b100, 32'h20, 32'h77, 1'b1, 1'b1);
    txn(1'b0, 3'b010, 32'h1000, 32'h0, 1'b0, 1'b1);
    txn(1'b0, 3'b000, 32'hFFF, 32'h0, 1'b0, 1'b1);

    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h5555AAAA;
    idle = 0;
    while (!req_ready && idle < 10) begin @(negedge clk); idle++; end
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rst_acc_mem_we", 32'(mem_we), 32'd0);
    check("rst_acc_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_after_resp", 32'(resp_valid), 32'd0);
    check("rst_after_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("rst_after_resp2", 32'(resp_valid), 32'd0);
    txn(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 1'b0);

    for (int t = 0; t < 250; t++) begin
      idle = $urandom_range(0, 2);
      repeat (idle) @(negedge clk);
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      n = 1 << f3[1:0];
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'($urandom_range(4088, 4104));
        default: addr = 32'($urandom_range(0, 127));
      endcase
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(n) - 1);
      txn(we, f3, addr, $urandom, 1'($urandom_range(0, 1)), idle == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
- Load/store initiator between the core's memory stage and the word-organised data memory (`dmem`).
- Accepts one load or store request per transaction through a valid/ready handshake.
- Drives the memory's `we`/`amp`/`a`/`wd` pins and captures the combinational read data.
- Returns a sign/zero-extended load result, or an error response for misaligned, out-of-range or illegal accesses.

Parameters:
- XLEN, 32: data/address width.
- BASE_ADDR, 32'h0000_0000: lowest legal byte address.
- SIZE_BYTES, 4096: legal window size in bytes; legal range is [BASE_ADDR, BASE_ADDR+SIZE_BYTES-1].

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  access rejected, valid with resp_valid
- mem_we  out  1  memory write enable
- mem_amp  out  4  byte-lane mask
- mem_a  out  XLEN  memory byte address
- mem_wd  out  XLEN  memory write data
- mem_rd  in  XLEN  memory combinational read data

Behaviour:
- FSM states: IDLE, ACC, RESP. Reset state is IDLE.
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_amp=0, mem_a=0, mem_wd=0.
- req_ready=1 only in IDLE and only while reset=0.
- IDLE: on req_valid&req_ready, latch we/funct3/addr/wdata. If the request is legal go to ACC, else go to RESP with err=1.
- ACC (exactly one cycle):
  - mem_a = latched addr.
  - mem_amp = lane mask.
  - mem_we = latched we & ~reset (combinational gate, so a reset during ACC suppresses the write at that edge).
  - For loads, mem_rd is sampled at the end of ACC, lane-selected, extended and registered into resp_rdata.
  - Next state RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. Outputs hold stable during RESP.
- Latency: accept at edge N, memory access cycle N+1, resp_valid high in cycle N+2. Maximum throughput is one request per 3 cycles. Error responses take 2 cycles (accept, RESP).
- Outside ACC: mem_we=0, mem_amp=0; mem_a and mem_wd hold their last value.
- Lane mask by offset addr[1:0]:
  - word: 1111.
  - half: 0011 at offset 0, 1100 at offset 2.
  - byte: 0001, 0010, 0100, 1000 for offsets 0..3.
- Write data is replicated across lanes:
  - sb: {4{wdata[7:0]}}.
  - sh: {2{wdata[15:0]}}.
  - sw: wdata.
- Load extraction:
  - Select the byte at addr[1:0] or the half at addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Illegal request (resp_err=1, no mem_we ever asserted, resp_rdata=0):
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  - funct3 ∈ {011, 110, 111}.
  - Store with funct3[2]=1.
  - Address outside [BASE_ADDR, BASE_ADDR+SIZE_BYTES-1], evaluated on the first byte address. Any legal aligned access then fits inside the window.
- req_valid while busy: ignored; the requester must hold it until it sees req_ready.
- Inputs are sampled only at the accept edge; later changes have no effect.
- Reset asserted in any state: IDLE next edge, resp_valid=0 that edge. A pending response is dropped.

Test Plan:
- **Store/load word:** reset, then sw addr=0x10 wdata=0xDEADBEEF. Expect mem_we=1 with amp=1111, mem_a=0x10, mem_wd=0xDEADBEEF for exactly one cycle, then resp_valid with err=0. Then lw 0x10 with mem_rd=0xDEADBEEF: resp_rdata=0xDEADBEEF in cycle N+2.
- **Sub-word stores:** sb addr=0x13 wdata=0x000000A5: amp=1000, wd=0xA5A5A5A5. sh addr=0x12 wdata=0x1234: amp=1100, wd=0x12341234.
- **Sign/zero extension:** mem_rd=0x80FF7F01. lb@+1 -> 0x0000007F; lb@+2 -> 0xFFFFFFFF; lbu@+3 -> 0x00000080; lh@+2 -> 0xFFFF80FF; lhu@+0 -> 0x00007F01.
- **Errors:** lw addr=0x2, sh addr=0x5, funct3=011, sb with funct3=100, and lw addr=0x1000 with SIZE_BYTES=4096. Each gives resp_err=1, resp_rdata=0, mem_we never 1, response in cycle N+1.
- **Handshake:** req_valid held high with back-to-back requests. req_ready is 1 only in IDLE; accepts occur every 3 cycles; a request changed while ready=0 is not executed.
- **Reset mid-operation:** assert reset during ACC of sw 0x20. mem_we=0 in that cycle, no resp_valid, IDLE afterwards, req_ready=1 the cycle after reset deasserts.
